fifo_ptr_ctrl: RTL and testbench
================================

Name: fifo_ptr_ctrl

Overview:
- Parametrised read/write pointer controller for a single-clock FIFO. Generates write and read addresses for a DEPTH-entry dual-port RAM.
- Qualifies the raw write/read requests into RAM enables, and produces full, empty, almost-full, almost-empty, occupancy count and sticky error flags.
- Sits between the producer/consumer request logic and the FIFO storage array.

Parameters:
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- write  in  1  producer write request.
- read  in  1  consumer read request.
- clear  in  1  synchronous flush: empties the FIFO and clears the error flags.
- wr_en  out  1  qualified write strobe to the RAM (combinational).
- rd_en  out  1  qualified read strobe to the RAM (combinational).
- write_addr  out  ADDR_W  RAM write address (lower bits of the write pointer).
- read_addr  out  ADDR_W  RAM read address (lower bits of the read pointer).
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Internal pointers wp and rp are ADDR_W+1 bits wide; the MSB is the wrap bit. write_addr = wp[ADDR_W-1:0]; read_addr = rp[ADDR_W-1:0].
- Reset (rst=1, asynchronous): wp=0, rp=0, count=0, overflow=0, underflow=0. Therefore fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0 (the last for AF_LEVEL>=1).
- Reset asserted mid-operation drops all state immediately; no pending operation completes.
- Enables: wr_en = write & ~fifo_full; rd_en = read & ~fifo_empty. Both are evaluated against the flags held in the current cycle.
- Pointer update on the rising edge:
  - wp increments when wr_en=1; rp increments when rd_en=1.
  - Increment is modulo 2**(ADDR_W+1); the address wraps from DEPTH-1 to 0 and the wrap bit toggles.
  - A pointer holds its value when its enable is low; it never returns to 0 on idle.
- count: +1 on write-only, -1 on read-only, unchanged when both or neither enable is active.
- Flags (combinational from registered state, valid the cycle after the causing edge):
  - fifo_empty = (wp == rp).
  - fifo_full = lower bits equal and wrap bits differ.
  - almost_full and almost_empty are compared against the registered count.
- Simultaneous write and read:
  - Not full and not empty: both happen, count unchanged.
  - Full: only the read happens (wr_en=0), count becomes DEPTH-1, overflow sets.
  - Empty: only the write happens (rd_en=0), count becomes 1, underflow sets.
- overflow sets on any cycle with write & fifo_full; underflow sets on any cycle with read & fifo_empty. Both stay set until clear or rst.
- clear (synchronous): next edge gives wp=rp=0, count=0, overflow=underflow=0. clear takes priority over write and read in the same cycle. wr_en and rd_en are still driven as defined above during clear; the RAM contents are don't-care after clear.
- Latency: the wr_en/rd_en strobe is combinational in the request cycle. Address, count and flags update on the following edge.

Test Plan (ADDR_W=3, DEPTH=8, AF=6, AE=2):
- Reset: assert rst mid-cycle → outputs immediately show wp=rp=0, count=0, empty=1, full=0, almost_empty=1, no errors.
- Fill: 8 consecutive writes → write_addr steps 0..7 then 0; almost_full rises at count=6; full=1 at count=8. 9th write gives wr_en=0, write_addr stays 0, overflow=1.
- Drain: 8 reads after fill → read_addr steps 0..7→0; almost_empty rises at count=2; empty=1. Extra read gives rd_en=0, underflow=1.
- Simultaneous: at count=4, write+read for 5 cycles → count stays 4, both addresses advance by 5 (wrap bit toggles). At full, write+read → count=7, overflow=1. At empty, write+read → count=1, underflow=1.
- Idle hold: 3 writes then 4 idle cycles → write_addr stays 3, count stays 3.
- Clear: with count=5 and overflow=1, pulse clear together with write → next cycle count=0, addresses 0, empty=1, overflow=0.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer controller for a single-clock FIFO.
// The pointers are one bit wider than the RAM address. The extra MSB is a
// wrap bit, so full and empty can be told apart while the addresses match.
// The occupancy count is kept in its own register. This lets the
// almost-full and almost-empty thresholds use a simple compare.
module fifo_ptr_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic              clear,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [ADDR_W-1:0] read_addr,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_THR   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR   = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W:0] wp_r, rp_r, count_r;
    logic            overflow_r, underflow_r;

    logic [ADDR_W:0] wp_next_s, rp_next_s, count_next_s;
    logic            overflow_next_s, underflow_next_s;
    logic            full_s, empty_s;

    // Status flags decoded from registered pointers/count, plus qualified RAM strobes
    always_comb begin
        empty_s      = (wp_r == rp_r);
        full_s       = (wp_r[ADDR_W-1:0] == rp_r[ADDR_W-1:0]) &&
                       (wp_r[ADDR_W] != rp_r[ADDR_W]);
        wr_en        = write & ~full_s;
        rd_en        = read & ~empty_s;
        fifo_empty   = empty_s;
        fifo_full    = full_s;
        almost_full  = (count_r >= AF_THR);
        almost_empty = (count_r <= AE_THR);
        write_addr   = wp_r[ADDR_W-1:0];
        read_addr    = rp_r[ADDR_W-1:0];
        count        = count_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

    // Next-state: clear flushes everything; otherwise advance pointers and track errors
    always_comb begin
        wp_next_s        = wp_r;
        rp_next_s        = rp_r;
        count_next_s     = count_r;
        overflow_next_s  = overflow_r | (write & full_s);
        underflow_next_s = underflow_r | (read & empty_s);
        if (clear) begin
            wp_next_s        = PTR_ZERO;
            rp_next_s        = PTR_ZERO;
            count_next_s     = PTR_ZERO;
            overflow_next_s  = 1'b0;
            underflow_next_s = 1'b0;
        end else begin
            if (wr_en) begin
                wp_next_s = wp_r + PTR_ONE;
            end else begin
                wp_next_s = wp_r;
            end
            if (rd_en) begin
                rp_next_s = rp_r + PTR_ONE;
            end else begin
                rp_next_s = rp_r;
            end
            case ({wr_en, rd_en})
                2'b10:   count_next_s = count_r + PTR_ONE;
                2'b01:   count_next_s = count_r - PTR_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r        <= PTR_ZERO;
            rp_r        <= PTR_ZERO;
            count_r     <= PTR_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wp_r        <= wp_next_s;
            rp_r        <= rp_next_s;
            count_r     <= count_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Testbench for fifo_ptr_ctrl (ADDR_W=3, DEPTH=8, AF=6, AE=2).
// A behavioural occupancy model is checked every cycle. Directed
// scenarios add literal expectations on top of that model.
module tb_fifo_ptr_ctrl;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write = 1'b0, read = 1'b0, clear = 1'b0;
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] write_addr, read_addr;
    logic              fifo_full, fifo_empty, almost_full, almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow, underflow;

    int checks = 0;
    int errors = 0;

    // model state: total accepted writes/reads since last flush
    int m_count = 0, m_wcnt = 0, m_rcnt = 0;
    bit m_ovf = 1'b0, m_unf = 1'b0;

    logic last_wr_en, last_rd_en;

    fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .write(write), .read(read), .clear(clear),
        .wr_en(wr_en), .rd_en(rd_en), .write_addr(write_addr), .read_addr(read_addr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: occupancy arithmetic from the request rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_wcnt = 0; m_rcnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            bit we, re;
            we = write && (m_count < DEPTH);
            re = read && (m_count > 0);
            if (clear) begin
                m_count = 0; m_wcnt = 0; m_rcnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
            end else begin
                if (write && m_count == DEPTH) m_ovf = 1'b1;
                if (read && m_count == 0) m_unf = 1'b1;
                if (we) m_wcnt++;
                if (re) m_rcnt++;
                m_count = m_count + int'(we) - int'(re);
            end
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("wr_en", wr_en, int'(write && m_count < DEPTH));
        chk("rd_en", rd_en, int'(read && m_count > 0));
        chk("write_addr", write_addr, m_wcnt % DEPTH);
        chk("read_addr", read_addr, m_rcnt % DEPTH);
        chk("count", count, m_count);
        chk("fifo_full", fifo_full, int'(m_count == DEPTH));
        chk("fifo_empty", fifo_empty, int'(m_count == 0));
        chk("almost_full", almost_full, int'(m_count >= AF));
        chk("almost_empty", almost_empty, int'(m_count <= AE));
        chk("overflow", overflow, int'(m_ovf));
        chk("underflow", underflow, int'(m_unf));
    end

    // apply one request cycle; called at posedge+1, returns at next posedge+1
    task automatic drive(input logic w, input logic r, input logic c);
        write = w; read = r; clear = c;
        #1;
        last_wr_en = wr_en;
        last_rd_en = rd_en;
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0; clear = 1'b0;
    endtask

    initial begin
        // reset phase
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // fill
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_waddr", write_addr, i);
            drive(1'b1, 1'b0, 1'b0);
            chk("fill_af", almost_full, int'(i + 1 >= 6));
        end
        chk("full_flag", fifo_full, 1);
        chk("full_count", count, 8);
        chk("full_waddr_wrap", write_addr, 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("ninth_wr_en", last_wr_en, 0);
        chk("ninth_waddr", write_addr, 0);
        chk("ninth_ovf", overflow, 1);

        // drain
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_raddr", read_addr, i);
            drive(1'b0, 1'b1, 1'b0);
            chk("drain_ae", almost_empty, int'(7 - i <= 2));
        end
        chk("drain_empty", fifo_empty, 1);
        chk("drain_raddr_wrap", read_addr, 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("extra_rd_en", last_rd_en, 0);
        chk("extra_unf", underflow, 1);

        // simultaneous at count 4
        drive(1'b0, 1'b0, 1'b1);
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 1'b1, 1'b0);
        chk("sim_count", count, 4);
        chk("sim_waddr", write_addr, 1);
        chk("sim_raddr", read_addr, 5);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        chk("sim_full", fifo_full, 1);
        drive(1'b1, 1'b1, 1'b0);
        chk("simfull_wr_en", last_wr_en, 0);
        chk("simfull_rd_en", last_rd_en, 1);
        chk("simfull_count", count, 7);
        chk("simfull_ovf", overflow, 1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("simempty_rd_en", last_rd_en, 0);
        chk("simempty_count", count, 1);
        chk("simempty_unf", underflow, 1);

        // idle hold
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        chk("idle_waddr", write_addr, 3);
        chk("idle_count", count, 3);

        // clear with write at count 5 and overflow set
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        chk("pre_clr_count", count, 5);
        chk("pre_clr_ovf", overflow, 1);
        drive(1'b1, 1'b0, 1'b1);
        chk("clrw_count", count, 0);
        chk("clrw_waddr", write_addr, 0);
        chk("clrw_raddr", read_addr, 0);
        chk("clrw_empty", fifo_empty, 1);
        chk("clrw_ovf", overflow, 0);

        // asynchronous reset mid-cycle
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", fifo_empty, 1);
        chk("arst_full", fifo_full, 0);
        chk("arst_ae", almost_empty, 1);
        chk("arst_waddr", write_addr, 0);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45 + ((n / 500) % 2) * 20);
            c = ($urandom_range(0, 199) == 0);
            drive(w, r, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
